muldiv4_seq_divider: RTL

//   Sequential restoring divider for the muldiv4 datapath; the inverse of the multiply path.

---
 rtl/muldiv4_pkg.sv | 13 +
 rtl/muldiv4_seq_divider_if.sv | 27 ++
 rtl/muldiv4_div_step.sv | 24 ++
 rtl/muldiv4_seq_divider.sv | 118 +++++++++++
 4 files changed

// File: rtl/muldiv4_pkg.sv
// rtl/muldiv4_pkg.sv - shared constants and FSM state type for the muldiv4 divider
package muldiv4_pkg;

    localparam int DIV_WIDTH = 4;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/muldiv4_seq_divider_if.sv
// rtl/muldiv4_seq_divider_if.sv - start/done handshake and operand/result bundle for the divider
interface muldiv4_seq_divider_if
    import muldiv4_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    // Requester side (control FSM / bench)
    modport master (
        output start, dividend, divisor,
        input  ready, done, quotient, remainder, div_by_zero
    );

    // Divider side
    modport slave (
        input  start, dividend, divisor,
        output ready, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/muldiv4_div_step.sv
// rtl/muldiv4_div_step.sv - one combinational restoring-division step
module muldiv4_div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             dvd_bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic             qbit_o
);
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] dsr_ext;
    logic [WIDTH+1:0] diff;

    assign shifted = {rem_i, dvd_bit_i};
    assign dsr_ext = {2'b00, divisor_i};
    assign diff    = shifted - dsr_ext;

    // Keep the subtraction only when the shifted remainder covers the divisor
    always_comb begin
        qbit_o = (shifted >= dsr_ext);
        rem_o  = qbit_o ? diff[WIDTH:0] : shifted[WIDTH:0];
    end
endmodule

// File: rtl/muldiv4_seq_divider.sv
// rtl/muldiv4_seq_divider.sv - sequential restoring divider, one quotient bit per clock; option MULDIV4_DIV_ZERO_FAST_EN
module muldiv4_seq_divider
    import muldiv4_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    muldiv4_seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    div_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   step_rem;
    logic             step_qbit;
    logic [WIDTH-1:0] quo_next;

    muldiv4_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .dvd_bit_i (dvd_q[WIDTH-1]),
        .divisor_i (dsr_q),
        .rem_o     (step_rem),
        .qbit_o    (step_qbit)
    );

    assign quo_next = {quo_q[WIDTH-2:0], step_qbit};

    // Next-state and datapath control: accept in IDLE, iterate in RUN, pulse done in DONE
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dsr_d       = dsr_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    dvd_d   = bus.dividend;
                    dsr_d   = bus.divisor;
                    rem_d   = '0;
                    quo_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    dbz_d   = (bus.divisor == '0);
                    state_d = ST_RUN;
`ifdef MULDIV4_DIV_ZERO_FAST_EN
                    // Zero divisor skips iteration; results match what the full loop yields
                    if (bus.divisor == '0) begin
                        state_d     = ST_DONE;
                        quotient_d  = '1;
                        remainder_d = bus.dividend;
                    end
`endif
                end
            end
            ST_RUN: begin
                rem_d = step_rem;
                dvd_d = dvd_q << 1;
                quo_d = quo_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d     = ST_DONE;
                    quotient_d  = quo_next;
                    remainder_d = step_rem[WIDTH-1:0];
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, iteration and result registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign bus.ready       = (state_q == ST_IDLE);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
endmodule
